// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI SRAM arbiter: FSM states, owner IDs and default limits.
package qspi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic OWNER_D = 1'b0;
    localparam logic OWNER_C = 1'b1;

    localparam int DEF_STARVE_LIMIT   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/arb_starve_counter.sv
// Bounded-starvation tracker: counts D grants taken while C waits and decides when C must win.
module arb_starve_counter
    import qspi_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic d_req,
    input  logic c_req,
    input  logic grant_valid,
    input  logic grant_owner,
    output logic select_c
);

    localparam logic [3:0] CNT_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    // C is only picked when it is actually requesting, so a saturated count never grants an idle C.
    assign select_c = c_req && ((starve_cnt == CNT_LIMIT) || !d_req);

    // Saturating count of D grants that overtook a waiting C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (grant_valid && (grant_owner == OWNER_C)) begin
            starve_cnt <= 4'd0;
        end else if (grant_valid && c_req) begin
            if (starve_cnt != CNT_LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= starve_cnt;
            end
        end else if (idle && !c_req) begin
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_cnt;
        end
    end

endmodule

// File: rtl/qspi_sram_arbiter.sv
// Two-requester arbiter (display D, CPU C) in front of a single-word QSPI SRAM controller.
// Define QSPI_SRAM_ARB_TIMEOUT_EN to add a watchdog that aborts a WAIT lasting TIMEOUT_CYCLES.
module qspi_sram_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 17,
    parameter int DATA_WIDTH     = 16,
    parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_ack,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] d_rdata,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_ack,
    output logic                  c_done,
    output logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  mem_start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_busy,
    input  logic                  mem_done,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err
);

    arb_state_t state;
    logic       owner;
    logic       select_c;
    logic       grant_valid;

`ifdef QSPI_SRAM_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    logic [WDOG_W-1:0] wdog;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 32'sd0);
`endif

    assign grant_valid = (state == IDLE) && !mem_busy && (d_req || c_req);

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .idle       (state == IDLE),
        .d_req      (d_req),
        .c_req      (c_req),
        .grant_valid(grant_valid),
        .grant_owner(select_c),
        .select_c   (select_c)
    );

    // Transaction sequencer; every output is a register, pulses default low each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWNER_D;
            d_ack     <= 1'b0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            c_ack     <= 1'b0;
            c_done    <= 1'b0;
            c_rdata   <= '0;
            mem_start <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
`ifdef QSPI_SRAM_ARB_TIMEOUT_EN
            wdog      <= '0;
`endif
        end else begin
            d_ack     <= 1'b0;
            d_done    <= 1'b0;
            c_ack     <= 1'b0;
            c_done    <= 1'b0;
            mem_start <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state     <= ISSUE;
                        owner     <= select_c;
                        mem_start <= 1'b1;
                        if (select_c == OWNER_C) begin
                            c_ack     <= 1'b1;
                            mem_we    <= c_we;
                            mem_addr  <= c_addr;
                            mem_wdata <= c_wdata;
                        end else begin
                            d_ack     <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= d_addr;
                            mem_wdata <= '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    // The controller never finishes in the start cycle, so mem_done is not looked at here.
                    state <= WAIT;
`ifdef QSPI_SRAM_ARB_TIMEOUT_EN
                    wdog  <= '0;
`endif
                end
                WAIT: begin
                    if (mem_done) begin
                        state <= IDLE;
                        if (owner == OWNER_C) begin
                            c_done <= 1'b1;
                            if (!mem_we) begin
                                c_rdata <= mem_rdata;
                            end else begin
                                c_rdata <= c_rdata;
                            end
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= mem_rdata;
                        end
`ifdef QSPI_SRAM_ARB_TIMEOUT_EN
                    end else if (wdog == WDOG_LAST) begin
                        state <= IDLE;
                        err   <= 1'b1;
                        if (owner == OWNER_C) begin
                            c_done  <= 1'b1;
                            c_rdata <= '0;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= '0;
                        end
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
`else
                    end else begin
                        state <= WAIT;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
